// File: rtl/button_cmd_queue.sv
// button_cmd_queue: latches debounced button presses and serialises them, lowest index first, into an in-order FIFO of button codes.
//   clk, rst    : clock; synchronous active-high reset
//   btn_pulse   : one-cycle press pulses, one bit per button
//   cmd_valid   : FIFO head holds a command
//   cmd_code    : button index at the head (0 when empty)
//   cmd_ready   : consumer accepts the head this cycle
//   fifo_count  : occupied FIFO entries
//   pending     : latched presses not yet enqueued
//   drop_cnt    : saturating count of cycles in which presses merged
//   clr_drop    : clears drop_cnt (wins over a same-cycle drop)
module button_cmd_queue #(
    parameter int NUM_BTN = 4,
    parameter int DEPTH   = 4,
    parameter int CODE_W  = $clog2(NUM_BTN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_BTN-1:0]       btn_pulse,
    output logic                     cmd_valid,
    output logic [CODE_W-1:0]        cmd_code,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [NUM_BTN-1:0]       pending,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_drop
);
    localparam int AW = $clog2(DEPTH);
    logic [CODE_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [NUM_BTN-1:0] enq_mask;
    logic [CODE_W-1:0]  enq_idx;
    logic               pop, enq, drop;
    always_comb begin
        enq_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) if (pending[i]) enq_idx = CODE_W'(i);
    end
    assign cmd_valid = fifo_count != '0;
    assign cmd_code  = cmd_valid ? mem[rd_ptr] : '0;
    assign pop       = cmd_valid & cmd_ready;
    // a full FIFO still accepts an enqueue when the head leaves in the same cycle
    assign enq       = (|pending) & ((fifo_count != (AW+1)'(DEPTH)) | pop);
    // isolate the lowest set pending bit
    assign enq_mask  = enq ? (pending & (~pending + NUM_BTN'(1))) : '0;
    // a pulse landing on the bit being enqueued re-arms it rather than merging
    assign drop      = |(btn_pulse & pending & ~enq_mask);
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_idx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            drop_cnt   <= '0;
        end else begin
            pending    <= (pending & ~enq_mask) | btn_pulse;
            wr_ptr     <= enq ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_count <= (enq && !pop) ? fifo_count + (AW+1)'(1) :
                          (pop && !enq) ? fifo_count - (AW+1)'(1) : fifo_count;
            drop_cnt   <= clr_drop ? '0 :
                          (drop && drop_cnt != 8'hff) ? drop_cnt + 8'd1 : drop_cnt;
        end
    end
endmodule
